// File: rtl/univ_reg_n.sv
// Universal WIDTH-bit register: hold/load/shift/rotate/up-down count with serial I/O and flags.
// Optional SYNC_CLR_EN macro adds a synchronous active-high clear input (clr).
module univ_reg_n #(
   parameter int unsigned         WIDTH   = 8,
   parameter logic [WIDTH-1:0]    RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef SYNC_CLR_EN
   input  logic             clr,
`endif
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_l,
   input  logic             sin_r,
   output logic [WIDTH-1:0] q,
   output logic             sout_l,
   output logic             sout_r,
   output logic             co,
   output logic             zero
);

   localparam int unsigned EXT_W = WIDTH + 1;

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_LOAD = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_SHR  = 3'b011;
   localparam logic [2:0] MODE_ROL  = 3'b100;
   localparam logic [2:0] MODE_ROR  = 3'b101;
   localparam logic [2:0] MODE_INC  = 3'b110;
   localparam logic [2:0] MODE_DEC  = 3'b111;

   logic [WIDTH-1:0] q_nxt;
   logic             co_nxt;
   logic [EXT_W-1:0] sum_ext;
   logic [EXT_W-1:0] diff_ext;
   logic             clr_act;

   // Extended-width arithmetic; the top bit is the carry (INC) or borrow (DEC).
   assign sum_ext  = {1'b0, q} + EXT_W'(1);
   assign diff_ext = {1'b0, q} - EXT_W'(1);

`ifdef SYNC_CLR_EN
   assign clr_act = clr;
`else
   assign clr_act = 1'b0;
`endif

   // Next-state selection; clear beats enable, which beats mode.
   always_comb begin
      q_nxt  = q;
      co_nxt = co;
      if (clr_act) begin
         q_nxt  = RST_VAL;
         co_nxt = 1'b0;
      end else if (en) begin
         case (mode)
            MODE_HOLD: co_nxt = 1'b0;
            MODE_LOAD: q_nxt  = d;
            MODE_SHL:  q_nxt  = {q[WIDTH-2:0], sin_l};
            MODE_SHR:  q_nxt  = {sin_r, q[WIDTH-1:1]};
            MODE_ROL:  q_nxt  = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:  q_nxt  = {q[0], q[WIDTH-1:1]};
            MODE_INC: begin
               q_nxt  = sum_ext[WIDTH-1:0];
               co_nxt = sum_ext[WIDTH];
            end
            MODE_DEC: begin
               q_nxt  = diff_ext[WIDTH-1:0];
               co_nxt = diff_ext[WIDTH];
            end
            default: q_nxt = q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q  <= RST_VAL;
         co <= 1'b0;
      end else begin
         q  <= q_nxt;
         co <= co_nxt;
      end
   end

   assign sout_l = q[WIDTH-1];
   assign sout_r = q[0];
   assign zero   = (q == '0);

endmodule

// File: tb/tb_univ_reg_n.sv
// Directed bench for univ_reg_n: 8-bit default instance plus a 4-bit instance with RST_VAL=4'hA.
// Build with SYNC_CLR_EN defined to also exercise the synchronous clear.
module tb_univ_reg_n;

   localparam logic [2:0] M_HOLD = 3'b000;
   localparam logic [2:0] M_LOAD = 3'b001;
   localparam logic [2:0] M_SHL  = 3'b010;
   localparam logic [2:0] M_SHR  = 3'b011;
   localparam logic [2:0] M_ROL  = 3'b100;
   localparam logic [2:0] M_ROR  = 3'b101;
   localparam logic [2:0] M_INC  = 3'b110;
   localparam logic [2:0] M_DEC  = 3'b111;

   typedef struct {
      logic       en;
      logic [2:0] mode;
      logic [7:0] d;
      logic       sl;
      logic       sr;
      logic [7:0] eq;
      logic       eco;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en, sin_l, sin_r;
   logic [2:0] mode;
   logic [7:0] d;
   logic [7:0] q;
   logic       sout_l, sout_r, co, zero;
`ifdef SYNC_CLR_EN
   logic       clr;
`endif

   logic       en4, sin_l4, sin_r4;
   logic [2:0] mode4;
   logic [3:0] d4, q4;
   logic       sout_l4, sout_r4, co4, zero4;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   univ_reg_n #(.WIDTH(8), .RST_VAL(8'h00)) dut (
      .clk(clk), .rst_n(rst_n),
`ifdef SYNC_CLR_EN
      .clr(clr),
`endif
      .en(en), .mode(mode), .d(d), .sin_l(sin_l), .sin_r(sin_r),
      .q(q), .sout_l(sout_l), .sout_r(sout_r), .co(co), .zero(zero)
   );

   univ_reg_n #(.WIDTH(4), .RST_VAL(4'hA)) dut4 (
      .clk(clk), .rst_n(rst_n),
`ifdef SYNC_CLR_EN
      .clr(1'b0),
`endif
      .en(en4), .mode(mode4), .d(d4), .sin_l(sin_l4), .sin_r(sin_r4),
      .q(q4), .sout_l(sout_l4), .sout_r(sout_r4), .co(co4), .zero(zero4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Full check of the 8-bit instance against an expected q and co.
   task automatic chk8(input string name, input logic [7:0] eq, input logic eco);
      chk({name, ".q"}, 32'(q), 32'(eq));
      chk({name, ".co"}, 32'(co), 32'(eco));
      chk({name, ".zero"}, 32'(zero), 32'(eq == 8'h00));
      chk({name, ".sout_l"}, 32'(sout_l), 32'(eq[7]));
      chk({name, ".sout_r"}, 32'(sout_r), 32'(eq[0]));
   endtask

   // Apply inputs, clock once, sample 1 time unit after the edge.
   task automatic step(input logic e, input logic [2:0] m, input logic [7:0] dv,
                       input logic sl, input logic sr);
      en = e; mode = m; d = dv; sin_l = sl; sin_r = sr;
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[$];

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] e4;
      logic       eco4;
      rst_n = 1'b0; en = 1'b0; mode = M_HOLD; d = 8'h00; sin_l = 1'b0; sin_r = 1'b0;
      en4 = 1'b0; mode4 = M_HOLD; d4 = 4'h0; sin_l4 = 1'b0; sin_r4 = 1'b0;
`ifdef SYNC_CLR_EN
      clr = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk8("reset", 8'h00, 1'b0);
      chk("reset4.q", 32'(q4), 32'h0000000A);
      chk("reset4.co", 32'(co4), 32'h0);
      rst_n = 1'b1;

      vecs.push_back('{1'b0, M_LOAD, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0});
      vecs.push_back('{1'b0, M_LOAD, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0});
      vecs.push_back('{1'b0, M_LOAD, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0});
      vecs.push_back('{1'b1, M_LOAD, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0});
      vecs.push_back('{1'b1, M_SHL,  8'h00, 1'b1, 1'b0, 8'h03, 1'b0});
      vecs.push_back('{1'b1, M_SHR,  8'h00, 1'b0, 1'b1, 8'h81, 1'b0});
      vecs.push_back('{1'b1, M_ROL,  8'h00, 1'b0, 1'b0, 8'h03, 1'b0});
      vecs.push_back('{1'b1, M_ROR,  8'h00, 1'b0, 1'b0, 8'h81, 1'b0});
      vecs.push_back('{1'b1, M_LOAD, 8'hFE, 1'b0, 1'b0, 8'hFE, 1'b0});
      vecs.push_back('{1'b1, M_INC,  8'h00, 1'b0, 1'b0, 8'hFF, 1'b0});
      vecs.push_back('{1'b1, M_INC,  8'h00, 1'b0, 1'b0, 8'h00, 1'b1});
      vecs.push_back('{1'b1, M_DEC,  8'h00, 1'b0, 1'b0, 8'hFF, 1'b1});
      vecs.push_back('{1'b1, M_DEC,  8'h00, 1'b0, 1'b0, 8'hFE, 1'b0});
      vecs.push_back('{1'b1, M_INC,  8'h00, 1'b0, 1'b0, 8'hFF, 1'b0});
      vecs.push_back('{1'b1, M_INC,  8'h00, 1'b0, 1'b0, 8'h00, 1'b1});
      vecs.push_back('{1'b1, M_LOAD, 8'h10, 1'b0, 1'b0, 8'h10, 1'b1});
      vecs.push_back('{1'b1, M_SHL,  8'h00, 1'b0, 1'b1, 8'h20, 1'b1});
      vecs.push_back('{1'b1, M_HOLD, 8'hFF, 1'b1, 1'b1, 8'h20, 1'b0});
      vecs.push_back('{1'b1, M_SHR,  8'h00, 1'b1, 1'b0, 8'h10, 1'b0});
      vecs.push_back('{1'b1, M_ROL,  8'h00, 1'b0, 1'b0, 8'h20, 1'b0});
      vecs.push_back('{1'b0, M_INC,  8'h00, 1'b0, 1'b0, 8'h20, 1'b0});
      vecs.push_back('{1'b1, M_LOAD, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
      vecs.push_back('{1'b1, M_DEC,  8'h00, 1'b0, 1'b0, 8'hFF, 1'b1});
      vecs.push_back('{1'b0, M_DEC,  8'h00, 1'b0, 1'b0, 8'hFF, 1'b1});
      vecs.push_back('{1'b1, M_ROR,  8'h00, 1'b0, 1'b0, 8'hFF, 1'b1});

      foreach (vecs[i]) begin
         step(vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].sl, vecs[i].sr);
         chk8($sformatf("vec%0d", i), vecs[i].eq, vecs[i].eco);
      end

      // Asynchronous reset mid-cycle with co=1 and q=A5.
      step(1'b1, M_LOAD, 8'hA5, 1'b0, 1'b0);
      chk8("preload", 8'hA5, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk8("async_rst", 8'h00, 1'b0);
      chk("async_rst4.q", 32'(q4), 32'h0000000A);
      // Reset held across an edge with a pending load.
      step(1'b1, M_LOAD, 8'h3C, 1'b0, 1'b0);
      chk8("rst_held", 8'h00, 1'b0);
      #2;
      rst_n = 1'b1;
      // First edge after release already executes the mode.
      @(posedge clk);
      #1;
      chk8("rst_release", 8'h3C, 1'b0);

      // 4-bit instance: 16 INCs from A wrap back to A, carry only on F->0.
      en = 1'b0;
      e4 = 4'hA;
      for (int k = 0; k < 16; k++) begin
         en4 = 1'b1; mode4 = M_INC;
         @(posedge clk);
         #1;
         eco4 = (e4 == 4'hF);
         e4   = e4 + 4'h1;
         chk($sformatf("inc4_%0d.q", k), 32'(q4), 32'(e4));
         chk($sformatf("inc4_%0d.co", k), 32'(co4), 32'(eco4));
      end
      chk("inc4_final", 32'(q4), 32'h0000000A);
      en4 = 1'b0;

`ifdef SYNC_CLR_EN
      step(1'b1, M_LOAD, 8'hFF, 1'b0, 1'b0);
      step(1'b1, M_INC, 8'h00, 1'b0, 1'b0);
      step(1'b1, M_LOAD, 8'h55, 1'b0, 1'b0);
      chk8("clr_pre", 8'h55, 1'b1);
      clr = 1'b1;
      step(1'b1, M_INC, 8'h00, 1'b0, 1'b0);
      clr = 1'b0;
      chk8("clr_en1", 8'h00, 1'b0);
      step(1'b1, M_LOAD, 8'h55, 1'b0, 1'b0);
      clr = 1'b1;
      step(1'b0, M_LOAD, 8'hFF, 1'b0, 1'b0);
      clr = 1'b0;
      chk8("clr_en0", 8'h00, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
